// File: rtl/decimator_stream.sv
// decimator_stream
//   Runtime-configurable stream decimator placed after the integrator-comb
//   filter. Keeps the first sample of every N accepted inputs (pick mode) or
//   emits the sum of each N-sample group (sum mode). The output is a single
//   registered stage with a valid/ready handshake.
//
// Ports
//   clk_i    clock
//   rst_i    synchronous active-high reset, highest priority
//   en_i     block enable; low clears counter/accumulator/valid_o, data_o holds
//   decim_i  decimation factor N (0 -> 1, above MAX_DECIM -> MAX_DECIM)
//   mode_i   0 = pick first sample of group, 1 = sum of group
//   data_i   signed input sample
//   valid_i  input sample valid
//   ready_o  block can accept a sample this cycle
//   data_o   signed output sample, OUT_BW wide
//   valid_o  data_o valid
//   ready_i  downstream accepts data_o
module decimator_stream #(
    parameter int DATA_BW   = 8,
    parameter int MAX_DECIM = 256,
    parameter int CNT_BW    = $clog2(MAX_DECIM + 1),
    parameter int OUT_BW    = DATA_BW + $clog2(MAX_DECIM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [CNT_BW-1:0]    decim_i,
    input  logic                 mode_i,
    input  logic [DATA_BW-1:0]   data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [OUT_BW-1:0]    data_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    logic [CNT_BW-1:0]        cnt_q;
    logic [CNT_BW-1:0]        n_q;
    logic                     mode_q;
    logic signed [OUT_BW-1:0] acc_q;

    logic [CNT_BW-1:0]        decim_eff;
    logic [CNT_BW-1:0]        n_cur;
    logic                     mode_cur;
    logic                     first;
    logic                     last;
    logic                     accept;
    logic signed [OUT_BW-1:0] sample_ext;
    logic signed [OUT_BW-1:0] acc_sum;

    always_comb begin
        decim_eff = decim_i;
        if (decim_i == '0) begin
            decim_eff = CNT_BW'(1);
        end else if (decim_i > CNT_BW'(MAX_DECIM)) begin
            decim_eff = CNT_BW'(MAX_DECIM);
        end
    end

    // The first sample of a group uses the live config inputs directly; the
    // same values are latched so later samples of the group are unaffected by
    // mid-group changes.
    assign first    = (cnt_q == '0);
    assign n_cur    = first ? decim_eff : n_q;
    assign mode_cur = first ? mode_i : mode_q;
    assign last     = (cnt_q == n_cur - CNT_BW'(1));

    assign sample_ext = {{(OUT_BW - DATA_BW){data_i[DATA_BW-1]}}, data_i};
    assign acc_sum    = first ? sample_ext : acc_q + sample_ext;

    // Disabled block swallows inputs, so it always reports ready.
    assign ready_o = !en_i | !valid_o | ready_i;
    assign accept  = en_i & valid_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            n_q     <= CNT_BW'(1);
            mode_q  <= 1'b0;
            acc_q   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (!en_i) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            valid_o <= 1'b0;
        end else begin
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (accept) begin
                if (first) begin
                    n_q    <= decim_eff;
                    mode_q <= mode_i;
                end
                cnt_q <= last ? '0 : cnt_q + CNT_BW'(1);
                acc_q <= acc_sum;
                // A new result overrides the clear above, so a transfer and a
                // reload in the same cycle leave valid_o high.
                if (!mode_cur && first) begin
                    data_o  <= sample_ext;
                    valid_o <= 1'b1;
                end else if (mode_cur && last) begin
                    data_o  <= acc_sum;
                    valid_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decimator_stream.sv
// tb_decimator_stream
//   Directed bench for decimator_stream with default parameters
//   (DATA_BW=8, MAX_DECIM=256, OUT_BW=16). Expected values are hand-computed.
module tb_decimator_stream;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [8:0]  decim_i;
    logic        mode_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;

    int total = 0;
    int bad   = 0;

    decimator_stream dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .decim_i (decim_i),
        .mode_i  (mode_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        valid_i = 1'b1;
        data_i  = d;
        tick();
    endtask

    task automatic idle();
        valid_i = 1'b0;
        tick();
    endtask

    logic [15:0] exp_pick;

    initial begin
        rst_i   = 1'b1;
        en_i    = 1'b1;
        decim_i = 9'd1;
        mode_i  = 1'b0;
        data_i  = 8'd0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);

        // pick mode, N=250, ramp 0..500
        decim_i = 9'd250;
        mode_i  = 1'b0;
        for (int i = 0; i <= 500; i++) begin
            send(8'(i));
            if (i == 0 || i == 250 || i == 500) begin
                if (i == 0)        exp_pick = 16'h0000;
                else if (i == 250) exp_pick = 16'hFFFA;
                else               exp_pick = 16'hFFF4;
                chk("pick_valid", 32'(valid_o), 32'd1);
                chk("pick_data", 32'(data_o), 32'(exp_pick));
            end else begin
                chk("pick_novalid", 32'(valid_o), 32'd0);
            end
        end
        idle();
        chk("pick_drain", 32'(valid_o), 32'd0);
        en_i = 1'b0;
        tick();
        en_i = 1'b1;

        // sum mode, N=4
        decim_i = 9'd4;
        mode_i  = 1'b1;
        send(8'd1);
        send(8'd2);
        send(8'd3);
        chk("sum_partial", 32'(valid_o), 32'd0);
        send(8'd4);
        chk("sum1_valid", 32'(valid_o), 32'd1);
        chk("sum1_data", 32'(data_o), 32'h000A);
        send(8'hFB);
        chk("sum_xfer", 32'(valid_o), 32'd0);
        send(8'hFB);
        send(8'hFB);
        send(8'hFB);
        chk("sum2_valid", 32'(valid_o), 32'd1);
        chk("sum2_data", 32'(data_o), 32'hFFEC);

        // sum extremes, N=256
        decim_i = 9'd256;
        for (int i = 0; i < 256; i++) begin
            send(8'h80);
            if (i == 254) chk("ext_neg_partial", 32'(valid_o), 32'd0);
        end
        chk("ext_neg_valid", 32'(valid_o), 32'd1);
        chk("ext_neg_data", 32'(data_o), 32'h8000);
        for (int i = 0; i < 256; i++) send(8'h7F);
        chk("ext_pos_valid", 32'(valid_o), 32'd1);
        chk("ext_pos_data", 32'(data_o), 32'h7F00);
        idle();

        // backpressure, N=1 pick
        decim_i = 9'd1;
        mode_i  = 1'b0;
        send(8'd10);
        chk("bp_first", 32'(data_o), 32'd10);
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'd11;
        #1;
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 32'(valid_o), 32'd1);
            chk("bp_hold_data", 32'(data_o), 32'd10);
            chk("bp_hold_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ready_o), 32'd1);
        tick();
        chk("bp_resume1", 32'(data_o), 32'd11);
        chk("bp_resume1_v", 32'(valid_o), 32'd1);
        send(8'd12);
        chk("bp_resume2", 32'(data_o), 32'd12);
        mode_i = 1'b1;
        send(8'hFD);
        chk("n1_sum_sext", 32'(data_o), 32'hFFFD);
        idle();
        chk("bp_drain", 32'(valid_o), 32'd0);

        // config change mid-group: 4 -> 2 after 2nd sample
        decim_i = 9'd4;
        mode_i  = 1'b1;
        send(8'd1);
        send(8'd2);
        decim_i = 9'd2;
        send(8'd3);
        chk("cfg_hold_n", 32'(valid_o), 32'd0);
        send(8'd4);
        chk("cfg_old_group", 32'(data_o), 32'd10);
        send(8'd5);
        chk("cfg_new_partial", 32'(valid_o), 32'd0);
        send(8'd6);
        chk("cfg_new_g1", 32'(data_o), 32'd11);
        send(8'd7);
        send(8'd8);
        chk("cfg_new_g2", 32'(data_o), 32'd15);

        // decim_i = 0 behaves as N=1
        decim_i = 9'd0;
        send(8'd9);
        chk("n0_data", 32'(data_o), 32'd9);
        chk("n0_valid", 32'(valid_o), 32'd1);
        send(8'hFF);
        chk("n0_data2", 32'(data_o), 32'hFFFF);

        // decim_i = 300 clamps to 256
        decim_i = 9'd300;
        for (int i = 0; i < 256; i++) begin
            send(8'd1);
            if (i == 254) chk("clamp_partial", 32'(valid_o), 32'd0);
        end
        chk("clamp_valid", 32'(valid_o), 32'd1);
        chk("clamp_data", 32'(data_o), 32'h0100);
        idle();

        // reset with pending output and ready_i low
        decim_i = 9'd4;
        mode_i  = 1'b1;
        ready_i = 1'b0;
        send(8'd7);
        send(8'd7);
        send(8'd7);
        send(8'd7);
        chk("rst_pend_valid", 32'(valid_o), 32'd1);
        chk("rst_pend_data", 32'(data_o), 32'd28);
        valid_i = 1'b0;
        rst_i   = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_drop_valid", 32'(valid_o), 32'd0);
        chk("rst_drop_data", 32'(data_o), 32'd0);

        // reset after 3 of 4 samples
        ready_i = 1'b1;
        send(8'd50);
        send(8'd50);
        send(8'd50);
        valid_i = 1'b0;
        rst_i   = 1'b1;
        tick();
        rst_i = 1'b0;
        send(8'd1);
        send(8'd2);
        send(8'd3);
        chk("rst_fresh_partial", 32'(valid_o), 32'd0);
        send(8'd4);
        chk("rst_fresh_valid", 32'(valid_o), 32'd1);
        chk("rst_fresh_data", 32'(data_o), 32'd10);

        // en_i low mid-group
        send(8'd100);
        send(8'd100);
        en_i    = 1'b0;
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'd50;
        #1;
        chk("en_low_ready", 32'(ready_o), 32'd1);
        tick();
        chk("en_low_valid", 32'(valid_o), 32'd0);
        chk("en_low_data_hold", 32'(data_o), 32'd10);
        tick();
        chk("en_low_discard", 32'(valid_o), 32'd0);
        en_i    = 1'b1;
        ready_i = 1'b1;
        send(8'd2);
        send(8'd2);
        send(8'd2);
        chk("en_fresh_partial", 32'(valid_o), 32'd0);
        send(8'd2);
        chk("en_fresh_valid", 32'(valid_o), 32'd1);
        chk("en_fresh_data", 32'(data_o), 32'd8);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
